// File: rtl/user_pkg.sv
// Shared constants, port indices and address decode for the user-domain OBI demultiplexer.
package user_pkg;

   localparam int unsigned NumSbrDefault      = 4;
   localparam logic [31:0] BaseAddrDefault    = 32'h2000_0000;
   localparam logic [31:0] PeriphRangeDefault = 32'h0000_1000;
   localparam logic [31:0] ErrRdata           = 32'hBADC_AB1E;

   typedef enum logic [3:0] {
      UserError    = 4'd0,
      UserPeriph1  = 4'd1,
      UserPeriph2  = 4'd2,
      UserPeriph3  = 4'd3,
      UserPeriph4  = 4'd4,
      UserPeriph5  = 4'd5,
      UserPeriph6  = 4'd6,
      UserPeriph7  = 4'd7,
      UserPeriph8  = 4'd8,
      UserPeriph9  = 4'd9,
      UserPeriph10 = 4'd10,
      UserPeriph11 = 4'd11,
      UserPeriph12 = 4'd12,
      UserPeriph13 = 4'd13,
      UserPeriph14 = 4'd14,
      UserPeriph15 = 4'd15
   } user_port_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StFull = 2'd2
   } demux_state_e;

   // Window index by shift; the addr >= base test keeps the subtraction from wrapping into range.
   function automatic logic [3:0] decode_port(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input int unsigned shift,
                                              input int unsigned num_sbr);
      logic [31:0] off_s;
      logic [31:0] idx_s;
      off_s = addr - base;
      idx_s = off_s >> shift;
      if ((addr >= base) && (idx_s < num_sbr)) begin
         decode_port = idx_s[3:0] + 4'd1;
      end else begin
         decode_port = 4'd0;
      end
   endfunction

endpackage

// File: rtl/user_obi_err_sbr.sv
// Internal error subordinate: grants at once and answers every request one cycle later with an error.
module user_obi_err_sbr
   import user_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        aid_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        rid_o
);

   logic rvalid_r;
   logic rid_r;

   assign gnt_o = req_i;

   // One-deep response pipeline; a request every cycle gives a response every cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid_r <= 1'b0;
         rid_r    <= 1'b0;
      end else begin
         rvalid_r <= req_i;
         rid_r    <= req_i ? aid_i : 1'b0;
      end
   end

   assign rvalid_o = rvalid_r;
   assign rdata_o  = rvalid_r ? ErrRdata : 32'h0000_0000;
   assign err_o    = rvalid_r;
   assign rid_o    = rid_r;

endmodule

// File: rtl/user_obi_demux.sv
// One-manager to NumSbr-subordinate OBI demux with a single locked target, an
// internal error subordinate for unmapped addresses, and a response watchdog.
module user_obi_demux
   import user_pkg::*;
#(
   parameter int unsigned NumSbr        = NumSbrDefault,
   parameter logic [31:0] BaseAddr      = BaseAddrDefault,
   parameter logic [31:0] PeriphRange   = PeriphRangeDefault,
   parameter int unsigned MaxTrans      = 4,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 mgr_req_i,
   output logic                 mgr_gnt_o,
   input  logic [31:0]          mgr_addr_i,
   input  logic                 mgr_we_i,
   input  logic [3:0]           mgr_be_i,
   input  logic [31:0]          mgr_wdata_i,
   input  logic                 mgr_aid_i,
   output logic                 mgr_rvalid_o,
   output logic [31:0]          mgr_rdata_o,
   output logic                 mgr_err_o,
   output logic                 mgr_rid_o,
   output logic [NumSbr-1:0]    sbr_req_o,
   input  logic [NumSbr-1:0]    sbr_gnt_i,
   output logic [31:0]          sbr_addr_o,
   output logic                 sbr_we_o,
   output logic [3:0]           sbr_be_o,
   output logic [31:0]          sbr_wdata_o,
   output logic                 sbr_aid_o,
   input  logic [NumSbr-1:0]    sbr_rvalid_i,
   input  logic [NumSbr*32-1:0] sbr_rdata_i,
   input  logic [NumSbr-1:0]    sbr_err_i,
   input  logic [NumSbr-1:0]    sbr_rid_i,
   input  logic                 stat_clr_i,
   output logic [15:0]          err_cnt_o,
   output logic                 timeout_o
);

   localparam int unsigned    PeriphShift = $clog2(PeriphRange);
   localparam logic [3:0]     MaxCnt      = 4'(MaxTrans);
   localparam int unsigned    WdW         = $clog2(TimeoutCycles + 1);
   localparam logic [WdW-1:0] WdLimit     = WdW'(TimeoutCycles);

   demux_state_e   state_r, state_s;
   logic [3:0]     cnt_r, cnt_s;
   logic [3:0]     target_r, target_s;
   logic [3:0]     sel_s;
   logic           admit_s;
   logic           sel_gnt_s;
   logic           hs_s;
   logic           err_req_s;
   logic           err_gnt_s;
   logic           err_rvalid_s;
   logic [31:0]    err_rdata_s;
   logic           err_err_s;
   logic           err_rid_s;
   logic           rsp_valid_s;
   logic [31:0]    rsp_rdata_s;
   logic           rsp_err_s;
   logic           rsp_rid_s;
   logic [15:0]    err_cnt_r;
   logic [WdW-1:0] wd_r;
   logic           timeout_r;

   assign sel_s = decode_port(mgr_addr_i, BaseAddr, PeriphShift, NumSbr);

   // Admission: anything from idle, only the locked target while busy, nothing when full.
   always_comb begin
      admit_s = 1'b0;
      case (state_r)
         StIdle:  admit_s = 1'b1;
         StBusy:  admit_s = (sel_s == target_r);
         StFull:  admit_s = 1'b0;
         default: admit_s = 1'b0;
      endcase
   end

   // Request fan-out and grant select; everything is forced low while reset is asserted.
   always_comb begin
      sbr_req_o = '0;
      sel_gnt_s = (sel_s == UserError) & err_gnt_s;
      for (int i = 0; i < NumSbr; i++) begin
         sbr_req_o[i] = ~rst_i & mgr_req_i & admit_s & (sel_s == 4'(i + 1));
         sel_gnt_s    = sel_gnt_s | (sbr_gnt_i[i] & (sel_s == 4'(i + 1)));
      end
   end

   assign err_req_s = ~rst_i & mgr_req_i & admit_s & (sel_s == UserError);
   assign mgr_gnt_o = ~rst_i & mgr_req_i & admit_s & sel_gnt_s;
   assign hs_s      = mgr_req_i & mgr_gnt_o;

   assign sbr_addr_o  = rst_i ? 32'h0000_0000 : mgr_addr_i;
   assign sbr_we_o    = ~rst_i & mgr_we_i;
   assign sbr_be_o    = rst_i ? 4'h0 : mgr_be_i;
   assign sbr_wdata_o = rst_i ? 32'h0000_0000 : mgr_wdata_i;
   assign sbr_aid_o   = ~rst_i & mgr_aid_i;

   user_obi_err_sbr u_err_sbr (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (err_req_s),
      .aid_i    (mgr_aid_i),
      .gnt_o    (err_gnt_s),
      .rvalid_o (err_rvalid_s),
      .rdata_o  (err_rdata_s),
      .err_o    (err_err_s),
      .rid_o    (err_rid_s)
   );

   // Response mux follows the locked target only.
   always_comb begin
      rsp_valid_s = (target_r == UserError) & err_rvalid_s;
      rsp_rdata_s = (target_r == UserError) ? err_rdata_s : 32'h0000_0000;
      rsp_err_s   = (target_r == UserError) & err_err_s;
      rsp_rid_s   = (target_r == UserError) & err_rid_s;
      for (int i = 0; i < NumSbr; i++) begin
         rsp_valid_s = rsp_valid_s | (sbr_rvalid_i[i] & (target_r == 4'(i + 1)));
         rsp_rdata_s = rsp_rdata_s | (sbr_rdata_i[i*32 +: 32] & {32{target_r == 4'(i + 1)}});
         rsp_err_s   = rsp_err_s | (sbr_err_i[i] & (target_r == 4'(i + 1)));
         rsp_rid_s   = rsp_rid_s | (sbr_rid_i[i] & (target_r == 4'(i + 1)));
      end
   end

   assign mgr_rvalid_o = ~rst_i & (state_r != StIdle) & rsp_valid_s;
   assign mgr_rdata_o  = rsp_rdata_s & {32{mgr_rvalid_o}};
   assign mgr_err_o    = rsp_err_s & mgr_rvalid_o;
   assign mgr_rid_o    = rsp_rid_s & mgr_rvalid_o;

   // Outstanding counter, target lock and state derived from the next count.
   always_comb begin
      cnt_s    = cnt_r;
      target_s = target_r;
      if (hs_s && !mgr_rvalid_o) begin
         cnt_s = cnt_r + 4'd1;
      end else if (!hs_s && mgr_rvalid_o) begin
         cnt_s = cnt_r - 4'd1;
      end else begin
         cnt_s = cnt_r;
      end
      if (hs_s && (state_r == StIdle)) begin
         target_s = sel_s;
      end else begin
         target_s = target_r;
      end
      if (cnt_s == 4'd0) begin
         state_s = StIdle;
      end else if (cnt_s == MaxCnt) begin
         state_s = StFull;
      end else begin
         state_s = StBusy;
      end
   end

   // FSM state, counter and target registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r  <= StIdle;
         cnt_r    <= 4'd0;
         target_r <= 4'd0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         target_r <= target_s;
      end
   end

   // Saturating decode-error counter; a clear in the same cycle as an error wins.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_cnt_r <= 16'd0;
      end else if (stat_clr_i) begin
         err_cnt_r <= 16'd0;
      end else if (err_req_s && (err_cnt_r != 16'hFFFF)) begin
         err_cnt_r <= err_cnt_r + 16'd1;
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   // Watchdog restarts on every response or when idle; the flag stays set until cleared.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wd_r      <= '0;
         timeout_r <= 1'b0;
      end else if (stat_clr_i) begin
         wd_r      <= '0;
         timeout_r <= 1'b0;
      end else if ((state_r != StIdle) && !mgr_rvalid_o) begin
         wd_r      <= (wd_r != WdLimit) ? wd_r + 1'b1 : wd_r;
         timeout_r <= timeout_r | (wd_r == WdLimit - 1'b1);
      end else begin
         wd_r      <= '0;
         timeout_r <= timeout_r;
      end
   end

   assign err_cnt_o = err_cnt_r;
   assign timeout_o = timeout_r;

endmodule

// File: tb/tb_user_obi_demux.sv
// Self-checking bench for user_obi_demux: decode vector table, response scoreboard,
// and hand-written sequences for full stall, target switch, watchdog and reset.
module tb_user_obi_demux;
   import user_pkg::*;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          mgr_req_i, mgr_gnt_o, mgr_we_i, mgr_aid_i;
   logic [31:0]   mgr_addr_i, mgr_wdata_i;
   logic [3:0]    mgr_be_i;
   logic          mgr_rvalid_o, mgr_err_o, mgr_rid_o;
   logic [31:0]   mgr_rdata_o;
   logic [N-1:0]  sbr_req_o, sbr_gnt_i, sbr_rvalid_i, sbr_err_i, sbr_rid_i;
   logic [31:0]   sbr_addr_o, sbr_wdata_o;
   logic          sbr_we_o, sbr_aid_o;
   logic [3:0]    sbr_be_o;
   logic [N*32-1:0] sbr_rdata_i;
   logic          stat_clr_i;
   logic [15:0]   err_cnt_o;
   logic          timeout_o;

   user_obi_demux #(.NumSbr(N), .BaseAddr(32'h2000_0000), .PeriphRange(32'h0000_1000),
                    .MaxTrans(4), .TimeoutCycles(1024)) dut (
      .clk_i(clk), .rst_i(rst),
      .mgr_req_i(mgr_req_i), .mgr_gnt_o(mgr_gnt_o), .mgr_addr_i(mgr_addr_i),
      .mgr_we_i(mgr_we_i), .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i), .mgr_aid_i(mgr_aid_i),
      .mgr_rvalid_o(mgr_rvalid_o), .mgr_rdata_o(mgr_rdata_o), .mgr_err_o(mgr_err_o), .mgr_rid_o(mgr_rid_o),
      .sbr_req_o(sbr_req_o), .sbr_gnt_i(sbr_gnt_i), .sbr_addr_o(sbr_addr_o), .sbr_we_o(sbr_we_o),
      .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o), .sbr_aid_o(sbr_aid_o),
      .sbr_rvalid_i(sbr_rvalid_i), .sbr_rdata_i(sbr_rdata_i), .sbr_err_i(sbr_err_i), .sbr_rid_i(sbr_rid_i),
      .stat_clr_i(stat_clr_i), .err_cnt_o(err_cnt_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        rid;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic        aid;
      logic [3:0]  gnt;
      logic [3:0]  exp_req;
      logic        exp_gnt;
      int          port;
   } vec_t;

   rsp_t sb_q[$];
   vec_t vecs[8];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   exp_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic e, input logic r);
      rsp_t x;
      x.rdata = d;
      x.err   = e;
      x.rid   = r;
      sb_q.push_back(x);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input logic [31:0] a, input logic aid);
      mgr_req_i   = 1'b1;
      mgr_addr_i  = a;
      mgr_aid_i   = aid;
      mgr_we_i    = a[2];
      mgr_be_i    = 4'hF;
      mgr_wdata_i = a ^ 32'h5A5A_5A5A;
   endtask

   task automatic respond(input int idx, input logic [31:0] d, input logic r);
      sbr_rvalid_i = '0;
      sbr_err_i    = '0;
      sbr_rvalid_i[idx] = 1'b1;
      sbr_rdata_i[idx*32 +: 32] = d;
      sbr_rid_i[idx] = r;
   endtask

   // Scoreboard: every response the manager sees must match the oldest expectation.
   always @(negedge clk) begin : monitor
      rsp_t e;
      if (!rst && mgr_rvalid_o) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_rvalid: got rdata %h, expected no response", mgr_rdata_o);
         end else begin
            e = sb_q.pop_front();
            check("response", {30'd0, mgr_err_o, mgr_rid_o, mgr_rdata_o}, {30'd0, e.err, e.rid, e.rdata});
         end
      end
   end

   initial begin
      logic [31:0] d;
      vecs[0] = '{32'h2000_1004, 1'b1, 4'b0010, 4'b0010, 1'b1, 2};
      vecs[1] = '{32'h2000_0000, 1'b0, 4'b0001, 4'b0001, 1'b1, 1};
      vecs[2] = '{32'h2000_3FFC, 1'b1, 4'b1000, 4'b1000, 1'b1, 4};
      vecs[3] = '{32'h2000_4000, 1'b1, 4'b1111, 4'b0000, 1'b1, 0};
      vecs[4] = '{32'h1FFF_FFFC, 1'b0, 4'b1111, 4'b0000, 1'b1, 0};
      vecs[5] = '{32'h2000_2ABC, 1'b0, 4'b0000, 4'b0100, 1'b0, 3};
      vecs[6] = '{32'hFFFF_FFF0, 1'b1, 4'b1111, 4'b0000, 1'b1, 0};
      vecs[7] = '{32'h2000_2000, 1'b0, 4'b0100, 4'b0100, 1'b1, 3};

      // Reset with busy-looking inputs: every output must stay low.
      rst = 1'b1;
      stat_clr_i = 1'b0;
      set_req(32'h2000_0000, 1'b1);
      sbr_gnt_i = 4'b1111;
      sbr_rvalid_i = 4'b1111;
      sbr_err_i = 4'b1111;
      sbr_rid_i = 4'b1111;
      sbr_rdata_i = {N{32'hFFFF_FFFF}};
      step();
      step();
      check("rst_gnt", 64'(mgr_gnt_o), 64'd0);
      check("rst_req", 64'(sbr_req_o), 64'd0);
      check("rst_rsp", {31'd0, mgr_rvalid_o, mgr_rdata_o}, 64'd0);
      check("rst_addr", 64'(sbr_addr_o), 64'd0);
      check("rst_stat", {47'd0, timeout_o, err_cnt_o}, 64'd0);
      mgr_req_i = 1'b0;
      sbr_gnt_i = '0;
      sbr_rvalid_i = '0;
      sbr_err_i = '0;
      sbr_rid_i = '0;
      rst = 1'b0;
      step();

      // Decode table: one transaction from idle per vector.
      for (int v = 0; v < 8; v++) begin
         set_req(vecs[v].addr, vecs[v].aid);
         sbr_gnt_i = vecs[v].gnt;
         #1;
         check($sformatf("v%0d_req", v), 64'(sbr_req_o), 64'(vecs[v].exp_req));
         check($sformatf("v%0d_gnt", v), 64'(mgr_gnt_o), 64'(vecs[v].exp_gnt));
         check($sformatf("v%0d_payload", v), {sbr_addr_o, sbr_wdata_o},
               {vecs[v].addr, vecs[v].addr ^ 32'h5A5A_5A5A});
         d = 32'hA000_0000 + 32'(vecs[v].port) * 32'h0001_0000 + {16'h0000, vecs[v].addr[15:0]};
         if (vecs[v].exp_gnt) begin
            if (vecs[v].port == 0) begin
               push(ErrRdata, 1'b1, vecs[v].aid);
               exp_err++;
            end else begin
               push(d, 1'b0, vecs[v].aid);
            end
         end
         step();
         mgr_req_i = 1'b0;
         sbr_gnt_i = '0;
         if (vecs[v].exp_gnt && (vecs[v].port > 0)) begin
            respond(vecs[v].port - 1, d, vecs[v].aid);
            sbr_rvalid_i[vecs[v].port % 4] = 1'b1;
            sbr_rdata_i[(vecs[v].port % 4)*32 +: 32] = 32'hDEAD_BEEF;
            sbr_rid_i[vecs[v].port % 4] = ~vecs[v].aid;
         end
         step();
         sbr_rvalid_i = '0;
         check($sformatf("v%0d_err_cnt", v), 64'(err_cnt_o), 64'(exp_err));
      end

      // Four outstanding to one port fill the pipe; the fifth waits for a response.
      sbr_gnt_i = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         set_req(32'h2000_0010 + 32'(k) * 32'd4, k[0]);
         #1;
         check($sformatf("fill%0d_gnt", k), 64'(mgr_gnt_o), 64'd1);
         push(32'h5000_0000 + 32'(k), 1'b0, k[0]);
         step();
      end
      set_req(32'h2000_0020, 1'b0);
      #1;
      check("full_gnt", 64'(mgr_gnt_o), 64'd0);
      check("full_req", 64'(sbr_req_o), 64'd0);
      step();
      respond(0, 32'h5000_0000, 1'b0);
      #1;
      check("full_gnt_rsp_cycle", 64'(mgr_gnt_o), 64'd0);
      step();
      sbr_rvalid_i = '0;
      #1;
      check("full_release_gnt", 64'(mgr_gnt_o), 64'd1);
      push(32'h5000_0004, 1'b0, 1'b0);
      step();
      mgr_req_i = 1'b0;
      for (int k = 1; k < 5; k++) begin
         respond(0, 32'h5000_0000 + 32'(k), (k < 4) ? k[0] : 1'b0);
         step();
      end
      sbr_rvalid_i = '0;

      // Target switch stalls until drained; same-cycle response and handshake keeps the count.
      sbr_gnt_i = 4'b0101;
      set_req(32'h2000_0100, 1'b1);
      #1;
      check("sw_first_gnt", 64'(mgr_gnt_o), 64'd1);
      push(32'h6000_0001, 1'b0, 1'b1);
      step();
      set_req(32'h2000_2100, 1'b0);
      #1;
      check("sw_stall_gnt", 64'(mgr_gnt_o), 64'd0);
      check("sw_stall_req", 64'(sbr_req_o), 64'd0);
      respond(0, 32'h6000_0001, 1'b1);
      step();
      sbr_rvalid_i = '0;
      #1;
      check("sw_gnt", 64'(mgr_gnt_o), 64'd1);
      check("sw_req", 64'(sbr_req_o), 64'(4'b0100));
      push(32'h6000_0002, 1'b0, 1'b0);
      step();
      set_req(32'h2000_2104, 1'b1);
      respond(2, 32'h6000_0002, 1'b0);
      #1;
      check("same_cycle_gnt", 64'(mgr_gnt_o), 64'd1);
      push(32'h6000_0003, 1'b0, 1'b1);
      step();
      sbr_rvalid_i = '0;
      set_req(32'h2000_0200, 1'b0);
      #1;
      check("cnt_kept_stall", 64'(mgr_gnt_o), 64'd0);
      respond(2, 32'h6000_0003, 1'b1);
      step();
      sbr_rvalid_i = '0;
      #1;
      check("drained_gnt", 64'(mgr_gnt_o), 64'd1);
      push(32'h6000_0004, 1'b0, 1'b0);
      step();
      mgr_req_i = 1'b0;
      respond(0, 32'h6000_0004, 1'b0);
      step();
      sbr_rvalid_i = '0;

      // Clear and error handshake in the same cycle: clear wins.
      set_req(32'h2000_8000, 1'b1);
      stat_clr_i = 1'b1;
      #1;
      check("errclr_gnt", 64'(mgr_gnt_o), 64'd1);
      push(ErrRdata, 1'b1, 1'b1);
      step();
      stat_clr_i = 1'b0;
      mgr_req_i = 1'b0;
      check("clr_wins", 64'(err_cnt_o), 64'd0);
      step();
      set_req(32'h2000_4000, 1'b0);
      push(ErrRdata, 1'b1, 1'b0);
      step();
      mgr_req_i = 1'b0;
      check("err_cnt_one", 64'(err_cnt_o), 64'd1);
      step();

      // Watchdog fires after exactly 1024 silent cycles and is sticky.
      sbr_gnt_i = 4'b0010;
      set_req(32'h2000_1000, 1'b0);
      push(32'h7000_0000, 1'b0, 1'b0);
      step();
      mgr_req_i = 1'b0;
      repeat (1023) step();
      check("wd_before", 64'(timeout_o), 64'd0);
      step();
      check("wd_fire", 64'(timeout_o), 64'd1);
      repeat (5) step();
      check("wd_sticky", 64'(timeout_o), 64'd1);
      stat_clr_i = 1'b1;
      step();
      stat_clr_i = 1'b0;
      check("wd_clear", 64'(timeout_o), 64'd0);
      respond(1, 32'h7000_0000, 1'b0);
      step();
      sbr_rvalid_i = '0;

      // Reset with three outstanding and a response in flight.
      sbr_gnt_i = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         set_req(32'h2000_0000, 1'b0);
         step();
      end
      respond(0, 32'h1234_5678, 1'b1);
      rst = 1'b1;
      #1;
      check("mid_rst_gnt", {62'd0, mgr_gnt_o, mgr_rvalid_o}, 64'd0);
      check("mid_rst_req", 64'(sbr_req_o), 64'd0);
      check("mid_rst_stat", {47'd0, timeout_o, err_cnt_o}, 64'd0);
      sb_q.delete();
      step();
      sbr_rvalid_i = '0;
      rst = 1'b0;
      set_req(32'h2000_3000, 1'b1);
      sbr_gnt_i = 4'b1000;
      #1;
      check("post_rst_gnt", 64'(mgr_gnt_o), 64'd1);
      check("post_rst_req", 64'(sbr_req_o), 64'(4'b1000));
      push(32'h8000_0000, 1'b0, 1'b1);
      step();
      mgr_req_i = 1'b0;
      respond(3, 32'h8000_0000, 1'b1);
      step();
      sbr_rvalid_i = '0;
      set_req(32'h3000_0000, 1'b0);
      push(ErrRdata, 1'b1, 1'b0);
      step();
      mgr_req_i = 1'b0;
      step();
      check("post_rst_err_cnt", 64'(err_cnt_o), 64'd1);

      step();
      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
